counter_seq_ctrl: RTL

Controller that sequences a WIDTH-bit up-counter. It holds a configuration (terminal value, prescale divide, one-shot or periodic mode) and runs the counter under start/stop/hold commands. It reports wrap (tick) and completion (done) pulses. It sits between a control host and the counter datapath, and replaces free-running counters wherever the count must be bounded, divided or gated.

---
 rtl/counter_seq_ctrl.sv | 83 ++++++++
 1 files changed

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: bounded, prescaled up-counter sequencer with start/stop/hold control
module counter_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic [PRE_W-1:0] cfg_prescale,
  input  logic             cfg_periodic,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             tick,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  state_t state;
  logic [WIDTH-1:0] lim;
  logic [PRE_W-1:0] psc;
  logic [PRE_W-1:0] pre;
  logic per;
  assign cfg_ready = state == IDLE;
  assign busy = state != IDLE;
  assign paused = state == PAUSE;
  // Sequencer: config capture in IDLE, then stop > hold > step; resuming from PAUSE steps on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      pre <= '0;
      tick <= 1'b0;
      done <= 1'b0;
      lim <= '1;
      psc <= '0;
      per <= 1'b1;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      if (state == IDLE) begin
        if (cfg_valid) begin
          lim <= cfg_limit;
          psc <= cfg_prescale;
          per <= cfg_periodic;
        end
        if (start) begin
          state <= RUN;
          count <= '0;
          pre <= '0;
        end
      end else if (stop) begin
        state <= IDLE;
        count <= '0;
        pre <= '0;
      end else if (hold) begin
        state <= PAUSE;
      end else begin
        state <= RUN;
        if (pre != psc) begin
          pre <= pre + 1'b1;
        end else begin
          pre <= '0;
          if (count != lim) begin
            count <= count + 1'b1;
          end else begin
            tick <= 1'b1;
            if (per) begin
              count <= '0;
            end else begin
              done <= 1'b1;
              state <= IDLE;
            end
          end
        end
      end
    end
  end
endmodule
